// File: rtl/id_hazard_ctl.sv
// id_hazard_ctl: decode-side stall/bubble/flush control with a 3-deep in-flight destination scoreboard
module id_hazard_ctl #(
  parameter bit          FORWARD   = 1'b1,
  parameter bit          RF_BYPASS = 1'b0,
  parameter int unsigned DRAIN     = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        id_valid_i,
  input  logic [2:0]  id_rx_i,
  input  logic [2:0]  id_ry_i,
  input  logic        id_rx_rd_i,
  input  logic        id_ry_rd_i,
  input  logic [2:0]  id_ro_i,
  input  logic        id_ro_wr_i,
  input  logic        id_is_load_i,
  input  logic        id_halt_i,
  input  logic        ex_redirect_i,
  output logic        pc_write_en_o,
  output logic        ifid_write_en_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        halted_o,
  output logic [15:0] stall_cycles_o
);
  localparam int CW = DRAIN > 2 ? $clog2(DRAIN) : 1;
  typedef enum logic [1:0] {RUN, DRN, HLT} state_e;
  typedef struct packed {logic v; logic [2:0] r; logic ld;} sb_t;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  sb_t [2:0]     sb_q, sb_d;
  logic [15:0]   stall_q, stall_d;
  logic [2:0]    match;
  logic          run, raw, stall, issue;
  // source-vs-in-flight destination compare for EX(0), MEM(1), WB(2)
  always_comb begin
    match = '0;
    for (int k = 0; k < 3; k++)
      match[k] = sb_q[k].v & ((id_rx_rd_i & (id_rx_i == sb_q[k].r)) | (id_ry_rd_i & (id_ry_i == sb_q[k].r)));
  end
  assign run   = state_q == RUN;
  assign raw   = FORWARD ? match[0] & sb_q[0].ld : match[0] | match[1] | (match[2] & ~RF_BYPASS);
  assign stall = id_valid_i & raw & ~ex_redirect_i & run;
  assign issue = id_valid_i & ~stall & ~ex_redirect_i & run;
  assign pc_write_en_o   = ex_redirect_i | (~stall & run);
  assign ifid_write_en_o = ex_redirect_i | (~stall & run);
  assign ifid_flush_o    = ex_redirect_i;
  assign idex_bubble_o   = ex_redirect_i | stall | ~run;
  assign halted_o        = state_q == HLT;
  assign stall_cycles_o  = stall_q;
  // next state: scoreboard shift, saturating stall count, halt drain FSM
  always_comb begin
    sb_d    = {sb_q[1:0], issue ? sb_t'({id_ro_wr_i, id_ro_i, id_is_load_i}) : sb_t'('0)};
    stall_d = stall_q + 16'(stall & ~&stall_q);
    state_d = state_q;
    cnt_d   = cnt_q;
    if (issue & id_halt_i) begin
      state_d = DRN;
      cnt_d   = CW'(DRAIN - 1);
    end else if (state_q == DRN) begin
      state_d = ex_redirect_i ? RUN : (cnt_q == '0 ? HLT : DRN);
      cnt_d   = ex_redirect_i || cnt_q == '0 ? '0 : cnt_q - 1'b1;
    end
  end
  // state registers, cleared immediately by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
      sb_q    <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sb_q    <= sb_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_id_hazard_ctl.sv
// tb_id_hazard_ctl: three parameterisations driven in lockstep, checked against an age-list reference model
module tb_id_hazard_ctl;
  typedef struct packed {logic [2:0] r; logic ld; logic [2:0] age;} rec_t;
  logic clk = 0, rst_n = 0;
  logic v = 0, rxr = 0, ryr = 0, wr = 0, ld = 0, hl = 0, rd = 0;
  logic [2:0] rx = 0, ry = 0, ro = 0;
  logic pc[3], iw[3], fo[3], bb[3], hd[3];
  logic [15:0] sc[3];
  rec_t fl[3][$];
  int halt_age[3], scnt[3];
  logic [20:0] expq[3][$];
  int tests = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    id_hazard_ctl #(.FORWARD(g == 0), .RF_BYPASS(g == 2), .DRAIN(g == 2 ? 2 : 3)) u (
      .clk_i(clk), .rst_ni(rst_n), .id_valid_i(v), .id_rx_i(rx), .id_ry_i(ry),
      .id_rx_rd_i(rxr), .id_ry_rd_i(ryr), .id_ro_i(ro), .id_ro_wr_i(wr),
      .id_is_load_i(ld), .id_halt_i(hl), .ex_redirect_i(rd),
      .pc_write_en_o(pc[g]), .ifid_write_en_o(iw[g]), .ifid_flush_o(fo[g]),
      .idex_bubble_o(bb[g]), .halted_o(hd[g]), .stall_cycles_o(sc[g]));
  end
  function automatic bit fw(int c); return c == 0; endfunction
  function automatic bit bp(int c); return c == 2; endfunction
  function automatic int dr(int c); return c == 2 ? 2 : 3; endfunction
  task automatic step(input bit r_n, iv, input logic [2:0] ix, iy, input bit ixr, iyr,
                      input logic [2:0] io, input bit iwr, ild, ihl, ird);
    @(posedge clk);
    #1;
    rst_n = r_n; v = iv; rx = ix; ry = iy; rxr = ixr; ryr = iyr;
    ro = io; wr = iwr; ld = ild; hl = ihl; rd = ird;
    for (int c = 0; c < 3; c++) begin
      bit hit, running, st, iss;
      rec_t nq[$];
      if (!r_n) begin
        fl[c].delete(); halt_age[c] = 0; scnt[c] = 0;
      end
      hit = 0;
      foreach (fl[c][i]) begin
        bit m = (ixr && ix == fl[c][i].r) || (iyr && iy == fl[c][i].r);
        int a = int'(fl[c][i].age);
        if (m && (fw(c) ? (a == 1 && fl[c][i].ld) : (a <= 2 || (a == 3 && !bp(c))))) hit = 1;
      end
      running = halt_age[c] == 0;
      st  = iv && hit && !ird && running;
      iss = iv && !st && !ird && running;
      expq[c].push_back({ird ? 4'b1111 : (st || !running) ? 4'b0001 : 4'b1100,
                         halt_age[c] > dr(c), 16'(scnt[c])});
      if (r_n) begin
        if (st && scnt[c] < 65535) scnt[c]++;
        foreach (fl[c][i]) if (fl[c][i].age < 3) nq.push_back('{fl[c][i].r, fl[c][i].ld, fl[c][i].age + 3'd1});
        if (iss && iwr) nq.push_back('{io, ild, 3'd1});
        fl[c] = nq;
        if (halt_age[c] > 0 && halt_age[c] <= dr(c) && ird) halt_age[c] = 0;
        else if (halt_age[c] > 0) halt_age[c] = halt_age[c] > dr(c) ? halt_age[c] : halt_age[c] + 1;
        else if (iss && ihl) halt_age[c] = 1;
      end
    end
  endtask
  task automatic idle(input int n);
    repeat (n) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  // monitor: every cycle the outputs are presented; pop and compare per configuration
  always @(negedge clk) begin
    cyc++;
    for (int c = 0; c < 3; c++) if (expq[c].size() > 0) begin
      logic [20:0] e, a;
      e = expq[c].pop_front();
      a = {pc[c], iw[c], fo[c], bb[c], hd[c], sc[c]};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cfg%0d cyc%0d {pc,ifid_we,flush,bubble,halted,stalls}: got %b_%0d want %b_%0d",
                 c, cyc, a[20:16], a[15:0], e[20:16], e[15:0]);
      end
    end
  end
  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    idle(1);
    step(1, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    repeat (4) step(1, 1, 3, 2, 1, 1, 1, 1, 0, 0, 0);
    idle(3);
    step(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    repeat (4) step(1, 1, 2, 3, 0, 1, 4, 1, 0, 0, 0);
    idle(3);
    step(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    step(1, 1, 5, 0, 1, 0, 6, 1, 0, 0, 1);
    idle(3);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(6);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int n = 0; n < 3000; n++) begin
      bit any_h = 0, r_n;
      for (int c = 0; c < 3; c++) if (halt_age[c] > dr(c)) any_h = 1;
      r_n = !((any_h && $urandom_range(0, 3) == 0) || $urandom_range(0, 150) == 0);
      step(r_n, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 25) == 0,
           !any_h && $urandom_range(0, 12) == 0);
    end
    @(negedge clk);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (expq[c].size() != 0) begin
        fails++;
        $display("FAIL cfg%0d drain: %0d expectations left, want 0", c, expq[c].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
